// File: rtl/sync_polarity_ctrl.sv
// rtl/sync_polarity_ctrl.sv - hsync/vsync polarity detection and correction, optional SYNC_POL_OVERRIDE_EN
// A channel commits an inversion only after LOCK_N consecutive agreeing duty measurements.

module sync_polarity_chan #(
  parameter int CNT_W  = 12,
  parameter int LOCK_N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic in_i,
  output logic inv_o,
  output logic locked_o
);

  localparam logic [1:0] ST_WAIT_EDGE = 2'd0;
  localparam logic [1:0] ST_ACQUIRE   = 2'd1;
  localparam logic [1:0] ST_LOCKED    = 2'd2;
  localparam logic [1:0] ST_NOSIG     = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       LOCK_N_C = 4'(LOCK_N);

  logic [1:0]       state_q, state_d;
  logic             s_q, s_d;
  logic [CNT_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             cand_q, cand_d;
  logic [3:0]       match_q, match_d;
  logic             inv_q, inv_d;

  logic             rise, dec;
  logic [3:0]       match_inc;
  logic [CNT_W-1:0] hi_inc, lo_inc;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cand_d  = cand_q;
    match_d = match_q;
    inv_d   = inv_q;

    rise      = tick_i & in_i & ~s_q;
    dec       = (hi_q > lo_q);
    match_inc = (dec == cand_q) ? (match_q + 4'd1) : 4'd1;
    hi_inc    = (hi_q == CNT_MAX) ? CNT_MAX : (hi_q + CNT_ONE);
    lo_inc    = (lo_q == CNT_MAX) ? CNT_MAX : (lo_q + CNT_ONE);

    if (tick_i) begin
      s_d = in_i;
      if (rise) begin
        // The edge sample is the first high sample of the new period.
        hi_d = CNT_ONE;
        lo_d = '0;
        case (state_q)
          ST_ACQUIRE: begin
            cand_d  = dec;
            match_d = match_inc;
            if (match_inc >= LOCK_N_C) begin
              state_d = ST_LOCKED;
              inv_d   = dec;
            end
          end
          ST_LOCKED: begin
            if (dec != inv_q) begin
              state_d = ST_ACQUIRE;
              cand_d  = dec;
              match_d = 4'd1;
            end
          end
          default: begin
            state_d = ST_ACQUIRE;
            match_d = '0;
          end
        endcase
      end else if (state_q != ST_NOSIG) begin
        if (in_i) begin
          hi_d = hi_inc;
        end else begin
          lo_d = lo_inc;
        end
        if ((hi_d == CNT_MAX) || (lo_d == CNT_MAX)) begin
          state_d = ST_NOSIG;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_EDGE;
      s_q     <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cand_q  <= 1'b0;
      match_q <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cand_q  <= cand_d;
      match_q <= match_d;
      inv_q   <= inv_d;
    end
  end

  assign inv_o    = inv_q;
  assign locked_o = (state_q == ST_LOCKED);

endmodule

module sync_polarity_ctrl #(
  parameter int H_CNT_W = 12,
  parameter int V_CNT_W = 11,
  parameter int LOCK_N  = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SYNC_POL_OVERRIDE_EN
  input  logic ovr_en,
  input  logic ovr_h,
  input  logic ovr_v,
`endif
  input  logic hs_in,
  input  logic vs_in,
  output logic hs_out,
  output logic vs_out,
  output logic inv_h,
  output logic inv_v,
  output logic locked_h,
  output logic locked_v,
  output logic locked
);

  logic hs_prev_q;
  logic v_tick;
  logic inv_h_c, inv_v_c, locked_h_c, locked_v_c;
  logic hs_out_q, vs_out_q;

  // The V channel counts lines, so it advances once per raw hsync rising edge.
  assign v_tick = hs_in & ~hs_prev_q;

  sync_polarity_chan #(.CNT_W(H_CNT_W), .LOCK_N(LOCK_N)) u_chan_h (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (1'b1),
    .in_i     (hs_in),
    .inv_o    (inv_h_c),
    .locked_o (locked_h_c)
  );

  sync_polarity_chan #(.CNT_W(V_CNT_W), .LOCK_N(LOCK_N)) u_chan_v (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (v_tick),
    .in_i     (vs_in),
    .inv_o    (inv_v_c),
    .locked_o (locked_v_c)
  );

`ifdef SYNC_POL_OVERRIDE_EN
  logic ovr_en_q, ovr_h_q, ovr_v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_en_q <= 1'b0;
      ovr_h_q  <= 1'b0;
      ovr_v_q  <= 1'b0;
    end else begin
      ovr_en_q <= ovr_en;
      ovr_h_q  <= ovr_h;
      ovr_v_q  <= ovr_v;
    end
  end

  assign inv_h    = ovr_en_q ? ovr_h_q : inv_h_c;
  assign inv_v    = ovr_en_q ? ovr_v_q : inv_v_c;
  assign locked_h = ovr_en_q | locked_h_c;
  assign locked_v = ovr_en_q | locked_v_c;
`else
  assign inv_h    = inv_h_c;
  assign inv_v    = inv_v_c;
  assign locked_h = locked_h_c;
  assign locked_v = locked_v_c;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_prev_q <= 1'b0;
      hs_out_q  <= 1'b0;
      vs_out_q  <= 1'b0;
    end else begin
      hs_prev_q <= hs_in;
      hs_out_q  <= hs_in ^ inv_h;
      vs_out_q  <= vs_in ^ inv_v;
    end
  end

  assign hs_out = hs_out_q;
  assign vs_out = vs_out_q;
  assign locked = locked_h & locked_v;

endmodule

// File: tb/tb_sync_polarity_ctrl.sv
// tb/tb_sync_polarity_ctrl.sv - directed self-checking bench for sync_polarity_ctrl

module tb_sync_polarity_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic hs_in, vs_in;
  logic hs_out, vs_out, inv_h, inv_v, locked_h, locked_v, locked;
`ifdef SYNC_POL_OVERRIDE_EN
  logic ovr_en, ovr_h, ovr_v;
`endif

  int tests = 0;
  int fails = 0;
  int line_no = 0;
  int h_ones = 0;
  logic exp_inv_h = 1'b0;
  logic exp_inv_v = 1'b0;
  logic [1:0] sb_q[$];

  always #5 clk = ~clk;

  sync_polarity_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef SYNC_POL_OVERRIDE_EN
    .ovr_en   (ovr_en),
    .ovr_h    (ovr_h),
    .ovr_v    (ovr_v),
`endif
    .hs_in    (hs_in),
    .vs_in    (vs_in),
    .hs_out   (hs_out),
    .vs_out   (vs_out),
    .inv_h    (inv_h),
    .inv_v    (inv_v),
    .locked_h (locked_h),
    .locked_v (locked_v),
    .locked   (locked)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // vsync source: 2 lines active-high out of every 20
  function automatic logic vpat(input int k);
    return (k % 20) < 2;
  endfunction

  task automatic cyc(input logic h, input logic v);
    logic [1:0] expv;
    hs_in = h;
    vs_in = v;
    sb_q.push_back({h ^ exp_inv_h, v ^ exp_inv_v});
    @(posedge clk);
    #1;
    expv = sb_q.pop_front();
    check("sync_out", {14'd0, hs_out, vs_out}, {14'd0, expv});
    if (hs_out === 1'b1) h_ones++;
  endtask

  task automatic line_start();
    cyc(1'b1, vpat(line_no));
  endtask

  task automatic line_finish(input int hi, input int lo);
    for (int i = 1; i < hi; i++) cyc(1'b1, vpat(line_no));
    for (int i = 0; i < lo; i++) cyc(1'b0, vpat(line_no));
    line_no++;
  endtask

  task automatic line(input int hi, input int lo);
    line_start();
    line_finish(hi, lo);
  endtask

  initial begin
    rst_n = 1'b0;
    hs_in = 1'b0;
    vs_in = 1'b0;
`ifdef SYNC_POL_OVERRIDE_EN
    ovr_en = 1'b0;
    ovr_h  = 1'b0;
    ovr_v  = 1'b0;
`endif
    #2;
    check("rst_out",    {14'd0, hs_out, vs_out},     16'd0);
    check("rst_inv",    {14'd0, inv_h, inv_v},       16'd0);
    check("rst_locked", {13'd0, locked_h, locked_v, locked}, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // active-high source: H locks on its 5th edge, V on its 5th frame edge (line 80)
    for (int k = 0; k < 4; k++) line(10, 90);
    check("h_no_lock_4_edges", {14'd0, locked_h, inv_h}, 16'b00);
    line_start();
    check("h_lock_5th_edge", {14'd0, locked_h, inv_h}, 16'b10);
    check("locked_waits_v", {15'd0, locked}, 16'd0);
    line_finish(10, 90);
    while (line_no < 80) line(10, 90);
    check("v_no_lock_yet", {14'd0, locked_v, inv_v}, 16'b00);
    line_start();
    check("v_lock_5th_edge", {14'd0, locked_v, inv_v}, 16'b10);
    check("locked_both", {15'd0, locked}, 16'd1);
    line_finish(10, 90);

`ifdef SYNC_POL_OVERRIDE_EN
    ovr_en = 1'b1;
    ovr_h  = 1'b1;
    ovr_v  = 1'b0;
    line_start();
    check("ovr_inv", {14'd0, inv_h, inv_v}, 16'b10);
    check("ovr_locked", {15'd0, locked}, 16'd1);
    exp_inv_h = 1'b1;
    ovr_en = 1'b0;
    cyc(1'b1, vpat(line_no));
    check("ovr_release", {14'd0, inv_h, inv_v}, 16'b00);
    exp_inv_h = 1'b0;
    line_finish(9, 90);
`endif

    // polarity flip while locked: 10/90 -> 90/10
    line(90, 10);
    check("flip_old_period", {14'd0, locked_h, inv_h}, 16'b10);
    line_start();
    check("flip_unlock_hold", {14'd0, locked_h, inv_h}, 16'b00);
    line_finish(90, 10);
    line(90, 10);
    line_start();
    check("flip_match3", {14'd0, locked_h, inv_h}, 16'b00);
    line_finish(90, 10);
    line_start();
    check("flip_relock", {14'd0, locked_h, inv_h}, 16'b11);
    exp_inv_h = 1'b1;
    line_finish(90, 10);
    h_ones = 0;
    line(90, 10);
    check("corrected_pulse_width", 16'(h_ones), 16'd10);

    // asynchronous reset in the low part of an active-low line
    line_start();
    line_finish(90, 3);
    check("pre_reset_hs_out", {15'd0, hs_out}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", {14'd0, hs_out, vs_out}, 16'd0);
    check("async_rst_inv", {14'd0, inv_h, inv_v}, 16'd0);
    check("async_rst_locked", {13'd0, locked_h, locked_v, locked}, 16'd0);
    exp_inv_h = 1'b0;
    hs_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    line_no = 0;

    // active-low source from reset
    for (int k = 0; k < 4; k++) line(90, 10);
    check("al_no_lock_4_edges", {14'd0, locked_h, inv_h}, 16'b00);
    line_start();
    check("al_lock", {14'd0, locked_h, inv_h}, 16'b11);
    check("al_locked_waits_v", {15'd0, locked}, 16'd0);
    exp_inv_h = 1'b1;
    line_finish(90, 10);
    line(90, 10);

    // hsync stuck low until the low counter saturates
    repeat (4000) cyc(1'b0, vpat(line_no));
    check("stuck_still_locked", {14'd0, locked_h, inv_h}, 16'b11);
    repeat (200) cyc(1'b0, vpat(line_no));
    check("nosig_unlock_hold", {14'd0, locked_h, inv_h}, 16'b01);
    line_start();
    check("nosig_arm", {14'd0, locked_h, inv_h}, 16'b01);
    line_finish(90, 10);
    line(90, 10);
    line(90, 10);
    line_start();
    check("nosig_match3", {14'd0, locked_h, inv_h}, 16'b01);
    line_finish(90, 10);
    line_start();
    check("nosig_relock", {14'd0, locked_h, inv_h}, 16'b11);
    line_finish(90, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_polarity_ctrl.md
# sync_polarity_ctrl

Detects hsync/vsync polarity of the incoming video timing and drives per-channel inversion so the text-overlay pipeline always sees active-high sync pulses. Sits at the video input, ahead of the character generator. Measures high/low duty per period, requires consecutive agreeing measurements before committing, and outputs polarity-corrected, registered sync signals plus lock status.

## Interface
- `H_CNT_W`, 12, width of hsync high/low counters (clock cycles)
- `V_CNT_W`, 11, width of vsync high/low counters (lines, i.e. hsync periods)
- `LOCK_N`, 4, consecutive agreeing evaluations needed to lock (1..15)
- `clk`  in  1  pixel clock; all inputs synchronous to it
- `rst_n`  in  1  asynchronous, active-low reset
- `hs_in`  in  1  raw hsync, unknown polarity
- `vs_in`  in  1  raw vsync, unknown polarity
- `hs_out`  out  1  registered `hs_in ^ inv_h`
- `vs_out`  out  1  registered `vs_in ^ inv_v`
- `inv_h`, `inv_v`  out  1  committed inversion per channel (1 = source active-low)
- `locked_h`, `locked_v`  out  1  channel in LOCKED state
- `locked`  out  1  `locked_h & locked_v`

## Operation
- Two identical channel FSMs: H ticks every clk; V ticks on each raw `hs_in` rising edge.
- Per channel: sample register `s_d`; rising edge = `in & ~s_d`; saturating `hi_cnt`/`lo_cnt`, plus `cand` (1 bit) and `match_cnt` (4 bits).
- Each tick: `hi_cnt++` if sample = 1, else `lo_cnt++`; saturate at all-ones.
- Evaluation on rising edge: `dec = (hi_cnt > lo_cnt)`; equal → `dec = 0`. Counters then restart with `hi_cnt = 1`, `lo_cnt = 0`.
- States:
  - WAIT_EDGE (reset state): first rising edge → ACQUIRE; no evaluation; counters restart.
  - ACQUIRE: on evaluation, if `dec == cand` then `match_cnt++`, else `cand = dec`, `match_cnt = 1`. When `match_cnt` reaches `LOCK_N` → LOCKED, `inv = cand` in the same update.
  - LOCKED: `dec == inv` → stay. `dec != inv` → ACQUIRE with `cand = dec`, `match_cnt = 1`; `inv` holds its old value.
  - NOSIG: entered from any state when either counter saturates. Counters freeze; next rising edge → ACQUIRE with a restart and no evaluation.
- `inv_*` changes only on entry to LOCKED; never glitches while acquiring.
- `locked_*` = 1 only in LOCKED.
- Reset mid-operation: all state is lost immediately; the channel restarts in WAIT_EDGE.

## Timing
- Reset values: `hs_out = vs_out = 0`, `inv_h = inv_v = 0`, `locked* = 0`, counters 0, FSMs in WAIT_EDGE.
- Edge is detected in the cycle where `hs_in = 1` and `s_d = 0`. FSM, `inv` and `locked` update at the end of that cycle and are visible the next cycle.
- `hs_out`/`vs_out` latency: 1 clk. They use `inv` as registered at the same edge, so an inversion change takes effect the cycle after lock.
- With a stable source, lock is reached at the (LOCK_N+1)-th rising edge after reset (first edge only arms the FSM).
- Simultaneous saturation and rising edge in one cycle: the rising edge wins and the evaluation proceeds normally.
- V channel tick coincides with the H rising-edge cycle; V evaluation uses counts that include that tick.

## Configuration
- `SYNC_POL_OVERRIDE_EN` defined: adds inputs `ovr_en`, `ovr_h`, `ovr_v`.
  - While `ovr_en = 1`, `inv_h = ovr_h` and `inv_v = ovr_v` (registered, 1-clk latency).
  - `locked*` report 1.
  - FSMs keep measuring; on release, `inv_*` return to the committed values.
- Undefined: ports absent; inversion comes only from measurement.

## Test plan
- Reset: assert `rst_n = 0` mid-stream → all outputs 0 in the same cycle (async); after release, no lock before 5 rising edges.
- Active-high H (10 high/90 low), V (2 lines high/18 low), `LOCK_N = 4` → `locked_h` at 5th hs edge + 1 clk, `inv_h = 0`; `locked` after 5th vs edge; `hs_out` = `hs_in` delayed 1 clk.
- Active-low H (90 high/10 low) → `inv_h = 1` at lock; `hs_out = ~hs_in` delayed 1 clk, active-high 10-cycle pulse.
- Polarity flip while locked (10/90 → 90/10) → `locked_h = 0` after first new evaluation, `inv_h` held at 0, then `inv_h = 1` and `locked_h = 1` after 4 matching evaluations.
- `hs_in` stuck at 0 for 4096 clk (`H_CNT_W = 12`) → NOSIG, `locked_h = 0`, `inv_h` held; resumed pulses → relock after the arming edge plus 4 evaluations.
- With `SYNC_POL_OVERRIDE_EN`: `ovr_en = 1`, `ovr_h = 1` on active-high source → `inv_h = 1` next clk; release → `inv_h = 0` next clk.
